ifetch_prefetch_queue: RTL
==========================

// Module: ifetch_prefetch_queue
// PURPOSE
// - Parametrised instruction fetch unit for the 8051 core; replaces the fixed 3-byte fetch stage.
// - Reads NBANK byte-wide synchronous ROM banks per access and buffers the fetched bytes in a DEPTH-byte queue.
// - Presents up to OUT_BYTES bytes at the head of the queue to the decoder. Decoder pops 0..out_count bytes per cycle.
// - A PC redirect (jump/call/ret/interrupt) flushes the queue, discards the in-flight read and restarts fetch at the new PC.
// PARAMETERS
// - ADDR_W    16  byte address width (PC width)
// - NBANK     4   ROM banks = bytes per fetch; power of two, >=2
// - DEPTH     8   queue capacity in bytes; power of two, >= NBANK+OUT_BYTES
// - OUT_BYTES 3   bytes exposed to the decoder (max 8051 instruction length)
// - RESET_PC  0   fetch address after reset
// PORTS
// - clk             in   1                        rising-edge clock
// - rst             in   1                        synchronous reset, active-high
// - redirect_valid  in   1                        load new PC, flush queue
// - redirect_pc     in   ADDR_W                   new fetch byte address
// - rom_rd          out  1                        ROM read strobe
// - rom_addr        out  NBANK*(ADDR_W-log2 NBANK) per-bank word address; bank i in slice i
// - rom_data        in   NBANK*8                  bank i byte in slice i; valid 1 cycle after rom_rd
// - out_bytes       out  OUT_BYTES*8              head byte in [7:0]; byte k = pc+k
// - out_count       out  clog2(OUT_BYTES+1)       valid head bytes, min(occupancy, OUT_BYTES)
// - out_pc          out  ADDR_W                   address of head byte
// - consume         in   clog2(OUT_BYTES+1)       bytes popped this cycle; consume<=out_count is the caller's duty
// - stall_cycles    out  32                       only with IFQ_PERF_EN
// BEHAVIOUR
// - Reset: out_count=0, out_pc=RESET_PC, fetch_pc=RESET_PC, queue empty, no read in flight, stall_cycles=0.
//   rom_rd is combinational and is 0 while rst is high.
// - Bank addressing (unaligned fetch): base = fetch_pc[ADDR_W-1:log2 NBANK], sel = fetch_pc[log2 NBANK-1:0].
//   Bank i address = base+1 when i<sel, else base; the +1 wraps modulo 2^(ADDR_W-log2 NBANK).
// - Return data is rotated by the sel registered at issue, so byte k = mem[fetch_pc+k].
//   The NBANK bytes are pushed at the end of the return cycle.
// - Issue rule: rom_rd=1 when !rst && !redirect_valid && (DEPTH - count - (inflight?NBANK:0)) >= NBANK.
//   count is the registered occupancy; same-cycle consume is not credited. On issue, fetch_pc += NBANK mod 2^ADDR_W.
// - Latency: an issue in cycle T gives bytes visible on out_* in T+2.
//   After reset deassert, the first issue is in the first non-reset cycle.
// - Push and pop in the same cycle are both applied: count' = count + push*NBANK - consume.
// - The queue never overflows, guaranteed by the issue rule.
// - Pop advances out_pc by consume, mod 2^ADDR_W.
// - Redirect (highest priority) in cycle T:
//   - queue cleared and consume ignored;
//   - any read issued in T-1 is tagged stale and its data dropped in T;
//   - fetch_pc and out_pc set to redirect_pc; no issue in T;
//   - out_count=0 from T+1; first new issue in T+1; new bytes visible in T+3.
// - Redirect during reset: rst wins.
// - Redirect on consecutive cycles: the last one wins.
// - Wrap-around: fetch past 2^ADDR_W-1 continues at 0; byte order stays contiguous.
// - States: S_RESET (rst high) -> S_RUN. Inflight flag plus stale flag form the fetch pipeline state.
//   S_RUN sub-status: FILL (issuing) / FULL (issue blocked).
// CONFIGURATION
// - IFQ_PERF_EN defined: stall_cycles counts cycles with out_count==0 and no redirect. Saturates at 2^32-1, cleared by rst.
// - IFQ_PERF_EN undefined: the stall_cycles port and counter are absent.
// STRUCTURE
// - Package ifetch_pkg: ADDR_W/NBANK defaults, function clog2, localparam SEL_W=clog2(NBANK), RESET_PC constant.
// - Sub-module ifetch_byte_queue: circular byte buffer.
//   - NBANK-wide push, 0..OUT_BYTES pop, flush, count output.
//   - Read/write pointers wrap modulo DEPTH.
// - Top level holds fetch_pc, inflight/stale flags, bank address generation, rotation and out_pc.
// TESTING (ROM model: mem[a]=a[7:0], 1-cycle read latency; NBANK=4, DEPTH=8)
// - Reset, consume=0:
//   - rom_rd=1 in the first cycle, bank addrs all 0;
//   - 2 cycles later out_count=3, out_bytes={02,01,00}, out_pc=0000;
//   - rom_rd drops once occupancy reaches 8.
// - Redirect to 0x0003: bank addrs {b3=0, b2=1, b1=1, b0=1}; 3 cycles later out_bytes={05,04,03}, out_pc=0003.
// - Steady consume=3 every cycle from 0x0100: out_pc steps 0100,0103,0106...
//   No byte skipped or repeated; out_count never exceeds occupancy.
// - Redirect to 0x0200 in the cycle a 0x0100 read returns: 0x01xx bytes never appear; next head out_pc=0200, byte 00.
// - Redirect to 0xFFFE: bytes FE,FF,00,01 are contiguous; rom_addr wraps 0x3FFF->0x0000.
// - IFQ_PERF_EN: hold consume=0 after fill; stall_cycles stays constant.
//   Redirect then 3 empty cycles: stall_cycles +2, redirect cycle excluded.

Source files
------------

// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared defaults, types and helpers for the instruction prefetch queue
package ifetch_pkg;

  // Ceiling log2 for elaboration-time width computation; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int IFQ_ADDR_W   = 16;
  localparam int IFQ_NBANK    = 4;
  localparam int SEL_W        = clog2(IFQ_NBANK);
  localparam int IFQ_RESET_PC = 0;

  // Top-level sequencing: held in S_RESET while rst is high, S_RUN otherwise.
  typedef enum logic {S_RESET, S_RUN} ifq_state_e;

  // Run sub-status: FILL while the queue can accept another full fetch, FULL otherwise.
  typedef enum logic {SUB_FILL, SUB_FULL} ifq_sub_e;

endpackage

// File: rtl/ifetch_byte_queue.sv
// rtl/ifetch_byte_queue.sv - circular byte buffer with NBANK-wide push and variable-width pop
module ifetch_byte_queue
  import ifetch_pkg::*;
#(
  parameter int NBANK     = 4,
  parameter int DEPTH     = 8,
  parameter int OUT_BYTES = 3,
  localparam int PW       = clog2(DEPTH),
  localparam int QC_W     = clog2(DEPTH + 1),
  localparam int CW       = clog2(OUT_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [NBANK*8-1:0]     push_data,
  input  logic [CW-1:0]          pop,
  output logic [OUT_BYTES*8-1:0] head_data,
  output logic [QC_W-1:0]        count
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Byte storage: a push writes NBANK consecutive slots; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int i = 0; i < NBANK; i++) begin
        mem[wr_ptr + PW'(i)] <= push_data[i*8 +: 8];
      end
    end
  end

  // Pointer and occupancy tracking; push and pop in the same cycle are both applied, flush wins.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(NBANK);
      end
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + (push ? QC_W'(NBANK) : QC_W'(0)) - QC_W'(pop);
    end
  end

  // Head window: the OUT_BYTES oldest slots, oldest in the low byte; slots past count are don't-care.
  always_comb begin
    head_data = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      head_data[k*8 +: 8] = mem[rd_ptr + PW'(k)];
    end
  end

endmodule

// File: rtl/ifetch_prefetch_queue.sv
// rtl/ifetch_prefetch_queue.sv - banked ROM instruction prefetcher with byte queue; IFQ_PERF_EN adds stall_cycles
module ifetch_prefetch_queue
  import ifetch_pkg::*;
#(
  parameter int ADDR_W    = IFQ_ADDR_W,
  parameter int NBANK     = IFQ_NBANK,
  parameter int DEPTH     = 8,
  parameter int OUT_BYTES = 3,
  parameter int RESET_PC  = IFQ_RESET_PC,
  localparam int BSEL_W   = clog2(NBANK),
  localparam int WA_W     = ADDR_W - BSEL_W,
  localparam int CW       = clog2(OUT_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   rom_rd,
  output logic [NBANK*WA_W-1:0]  rom_addr,
  input  logic [NBANK*8-1:0]     rom_data,
  output logic [OUT_BYTES*8-1:0] out_bytes,
  output logic [CW-1:0]          out_count,
  output logic [ADDR_W-1:0]      out_pc,
  input  logic [CW-1:0]          consume
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int QC_W = clog2(DEPTH + 1);
  localparam int SP_W = QC_W + 1;

  ifq_state_e state;
  ifq_state_e state_nxt;
  ifq_sub_e   sub;

  logic [ADDR_W-1:0]  fetch_pc;
  logic [BSEL_W-1:0]  issue_sel;
  logic               inflight;
  logic               stale;
  logic               push;
  logic [NBANK*8-1:0] push_data;
  logic [CW-1:0]      pop;
  logic [QC_W-1:0]    q_count;
  logic [SP_W-1:0]    committed;
  logic [BSEL_W-1:0]  bank_idx [NBANK];

  // Sequencing state register: S_RESET while rst is asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave S_RESET on the first non-reset edge and stay in S_RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET: state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_RESET;
    endcase
  end

  // Space already promised: registered occupancy plus the in-flight fetch; same-cycle pops earn no credit.
  always_comb begin
    committed = {1'b0, q_count} + (inflight ? SP_W'(NBANK) : SP_W'(0));
  end

  // Outputs of the sequencer: FILL/FULL sub-status and the combinational read strobe.
  always_comb begin
    sub    = (committed <= SP_W'(DEPTH - NBANK)) ? SUB_FILL : SUB_FULL;
    rom_rd = !rst && !redirect_valid && (sub == SUB_FILL);
  end

  // Unaligned bank addressing: banks below the start lane read the next word, wrapping in word space.
  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NBANK; i++) begin
      rom_addr[i*WA_W +: WA_W] = fetch_pc[ADDR_W-1:BSEL_W]
                                 + ((BSEL_W'(i) < fetch_pc[BSEL_W-1:0]) ? WA_W'(1) : WA_W'(0));
    end
  end

  // Fetch pipeline: remember the start lane of each issue so the return can be rotated into order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= ADDR_W'(RESET_PC);
      inflight  <= 1'b0;
      issue_sel <= '0;
    end else begin
      inflight <= rom_rd;
      if (rom_rd) begin
        issue_sel <= fetch_pc[BSEL_W-1:0];
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
      end else if (rom_rd) begin
        fetch_pc <= fetch_pc + ADDR_W'(NBANK);
      end
    end
  end

  // Return path: data arriving in a redirect cycle belongs to the old stream and is dropped.
  always_comb begin
    stale     = inflight && redirect_valid;
    push      = inflight && !stale;
    pop       = redirect_valid ? CW'(0) : consume;
    push_data = '0;
    for (int k = 0; k < NBANK; k++) begin
      bank_idx[k]          = issue_sel + BSEL_W'(k);
      push_data[k*8 +: 8]  = rom_data[{bank_idx[k], 3'b000} +: 8];
    end
  end

  ifetch_byte_queue #(
    .NBANK     (NBANK),
    .DEPTH     (DEPTH),
    .OUT_BYTES (OUT_BYTES)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (out_bytes),
    .count     (q_count)
  );

  // Decoder view: head address follows pops and jumps to the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc <= ADDR_W'(RESET_PC);
    end else if (redirect_valid) begin
      out_pc <= redirect_pc;
    end else begin
      out_pc <= out_pc + ADDR_W'(consume);
    end
  end

  // Valid head bytes are capped at the decoder window width.
  always_comb begin
    out_count = (q_count >= QC_W'(OUT_BYTES)) ? CW'(OUT_BYTES) : CW'(q_count);
  end

`ifdef IFQ_PERF_EN
  // Starvation counter: cycles with nothing to decode, redirect cycles excluded, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((out_count == '0) && !redirect_valid && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
